// File: rtl/oam_dma.sv
// Sprite attribute DMA: a CPU write to the DMA register copies OAM_BYTES bytes from {src_hi,8'h00} into OAM.
// Latency: one START slot, then one CYCLES_PER_BYTE-clock slot per byte (read at slot clock 0, write at clock 1).
// No backpressure: memory answers in exactly one clock; a retrigger aborts and restarts the copy.
module oam_dma #(
  parameter logic [15:0] DMA_REG_ADDR    = 16'hFF46,
  parameter int          OAM_BYTES       = 160,
  parameter int          CYCLES_PER_BYTE = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [15:0] cpu_addr,
  input  logic [7:0]  cpu_wdata,
  input  logic        cpu_we,
  output logic        reg_hit,
  output logic [7:0]  cpu_rdata,
  output logic        dma_rd,
  output logic [15:0] dma_addr,
  input  logic [7:0]  dma_rdata,
  output logic        oam_we,
  output logic [7:0]  oam_addr,
  output logic [7:0]  oam_wdata,
  output logic        busy,
  output logic        cpu_block
);

  localparam int CW = (CYCLES_PER_BYTE > 2) ? $clog2(CYCLES_PER_BYTE) : 1;
  localparam logic [CW-1:0] SLOT_LAST = CW'(CYCLES_PER_BYTE - 1);
  localparam logic [7:0]    IDX_LAST  = 8'(OAM_BYTES - 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    XFER  = 2'd2
  } state_t;

  state_t        state, state_nxt;
  logic [CW-1:0] cnt, cnt_nxt;
  logic [7:0]    idx, idx_nxt;
  logic [7:0]    src_hi;
  logic [7:0]    eff_hi;
  logic          trigger;
  logic          slot_end;

  // Last driven values, so the address/data buses stay put between strobes.
  logic [15:0]   dma_addr_q;
  logic [7:0]    oam_addr_q;
  logic [7:0]    oam_wdata_q;

  assign reg_hit   = (cpu_addr == DMA_REG_ADDR);
  assign cpu_rdata = src_hi;
  assign trigger   = cpu_we && reg_hit;
  assign slot_end  = (cnt == SLOT_LAST);

  // E0..FF is the echo of C0..DF; the register itself keeps the value written.
  assign eff_hi = (src_hi >= 8'hE0) ? (src_hi & 8'hDF) : src_hi;

  assign busy      = (state != IDLE);
  assign cpu_block = (state == XFER);
  assign dma_rd    = (state == XFER) && (cnt == CW'(0));
  assign oam_we    = (state == XFER) && (cnt == CW'(1));

  assign dma_addr  = dma_rd ? {eff_hi, idx} : dma_addr_q;
  assign oam_addr  = oam_we ? idx : oam_addr_q;
  assign oam_wdata = oam_we ? dma_rdata : oam_wdata_q;

  // State, slot counter, byte index and source register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state  <= IDLE;
      cnt    <= '0;
      idx    <= '0;
      src_hi <= '0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
      idx   <= idx_nxt;
      if (trigger) src_hi <= cpu_wdata;
    end
  end

  // Next-state: walk slots, advance idx at each slot end; a trigger overrides everything.
  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    idx_nxt   = idx;
    case (state)
      START: begin
        if (slot_end) begin
          state_nxt = XFER;
          cnt_nxt   = '0;
        end else begin
          cnt_nxt = cnt + CW'(1);
        end
      end
      XFER: begin
        if (slot_end) begin
          cnt_nxt = '0;
          if (idx == IDX_LAST) begin
            state_nxt = IDLE;
            idx_nxt   = '0;
          end else begin
            idx_nxt = idx + 8'd1;
          end
        end else begin
          cnt_nxt = cnt + CW'(1);
        end
      end
      default: begin
        state_nxt = IDLE;
        cnt_nxt   = '0;
        idx_nxt   = '0;
      end
    endcase
    if (trigger) begin
      state_nxt = START;
      cnt_nxt   = '0;
      idx_nxt   = '0;
    end
  end

  // Capture bus values whenever a strobe is issued.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      dma_addr_q  <= '0;
      oam_addr_q  <= '0;
      oam_wdata_q <= '0;
    end else begin
      if (dma_rd) dma_addr_q <= dma_addr;
      if (oam_we) begin
        oam_addr_q  <= oam_addr;
        oam_wdata_q <= oam_wdata;
      end
    end
  end

endmodule

// File: tb/tb_oam_dma.sv
// Randomized bench for oam_dma: a timeline model derived from the trigger time predicts every clock.
// Clock-by-clock comparison of strobes/buses, plus copy-level counts and final OAM contents.
// Inputs driven #1 after the rising edge, outputs sampled on the falling edge.
module tb_oam_dma;

  localparam logic [15:0] REG = 16'hFF46;
  localparam int NB  = 160;
  localparam int CPB = 4;
  localparam int BUSY_LEN = (1 + NB) * CPB;

  logic        clk = 1'b0;
  logic        reset;
  logic [15:0] cpu_addr;
  logic [7:0]  cpu_wdata;
  logic        cpu_we;
  logic        reg_hit;
  logic [7:0]  cpu_rdata;
  logic        dma_rd;
  logic [15:0] dma_addr;
  logic [7:0]  dma_rdata;
  logic        oam_we;
  logic [7:0]  oam_addr;
  logic [7:0]  oam_wdata;
  logic        busy;
  logic        cpu_block;

  oam_dma #(.DMA_REG_ADDR(REG), .OAM_BYTES(NB), .CYCLES_PER_BYTE(CPB)) dut (
    .clk(clk), .reset(reset), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata), .cpu_we(cpu_we),
    .reg_hit(reg_hit), .cpu_rdata(cpu_rdata), .dma_rd(dma_rd), .dma_addr(dma_addr),
    .dma_rdata(dma_rdata), .oam_we(oam_we), .oam_addr(oam_addr), .oam_wdata(oam_wdata),
    .busy(busy), .cpu_block(cpu_block)
  );

  always #5 clk = ~clk;

  logic [7:0] mem [0:65535];
  logic [7:0] tb_oam [0:255];
  logic [7:0] model_oam [0:255];
  logic [7:0] snap_oam [0:255];

  // Main memory: one-clock read latency.
  always @(posedge clk) if (dma_rd) dma_rdata <= mem[dma_addr];

  int tests = 0;
  int fails = 0;
  int cyc   = 0;

  // Model state: the most recent accepted trigger fully determines the timeline.
  int         trig_t = -1;
  logic [7:0] model_src = 8'h00;
  logic [15:0] last_ra = '0;
  logic [7:0]  last_wa = '0, last_wd = '0;

  int busy_cnt, we_cnt, first_we, first_rd;
  logic [15:0] first_rd_addr;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  task automatic clear_stats();
    busy_cnt = 0; we_cnt = 0; first_we = -1; first_rd = -1; first_rd_addr = '0;
  endtask

  task automatic model_reset();
    trig_t = -1; model_src = 8'h00; last_ra = '0; last_wa = '0; last_wd = '0;
  endtask

  // Expected outputs in clock c, from the trigger time and slot arithmetic.
  task automatic expect_at(input int c, output logic eb, output logic eblk, output logic erd,
                           output logic ewe, output logic [15:0] era, output logic [7:0] ewa,
                           output logic [7:0] ewd);
    int d, k, r;
    logic [7:0] eff;
    eb = 0; eblk = 0; erd = 0; ewe = 0; era = '0; ewa = '0; ewd = '0;
    if (trig_t >= 0 && c >= trig_t) begin
      d = c - trig_t;
      if (d < BUSY_LEN) begin
        eb = 1;
        if (d >= CPB) begin
          eblk = 1;
          k = (d - CPB) / CPB;
          r = (d - CPB) % CPB;
          eff = (model_src >= 8'hE0) ? model_src - 8'h20 : model_src;
          if (r == 0) begin erd = 1; era = {eff, 8'(k)}; end
          if (r == 1) begin ewe = 1; ewa = 8'(k); ewd = mem[{eff, 8'(k)}]; end
        end
      end
    end
  endtask

  // Compare one clock against the model, then advance past the next rising edge.
  task automatic cycle_check();
    logic eb, eblk, erd, ewe;
    logic [15:0] era;
    logic [7:0] ewa, ewd;
    @(negedge clk);
    expect_at(cyc, eb, eblk, erd, ewe, era, ewa, ewd);
    if (erd) last_ra = era;
    if (ewe) begin last_wa = ewa; last_wd = ewd; model_oam[ewa] = ewd; end
    check("busy", busy, eb);
    check("cpu_block", cpu_block, eblk);
    check("dma_rd", dma_rd, erd);
    check("oam_we", oam_we, ewe);
    check("dma_addr", dma_addr, last_ra);
    check("oam_addr", oam_addr, last_wa);
    check("oam_wdata", oam_wdata, last_wd);
    check("reg_hit", reg_hit, cpu_addr == REG);
    check("cpu_rdata", cpu_rdata, model_src);
    if (busy) busy_cnt++;
    if (dma_rd && first_rd < 0) begin first_rd = cyc; first_rd_addr = dma_addr; end
    if (oam_we) begin
      we_cnt++;
      if (first_we < 0) first_we = cyc;
      tb_oam[oam_addr] = oam_wdata;
    end
    @(posedge clk);
    cyc++;
    #1;
  endtask

  // Write the DMA register; the trigger is sampled on the edge inside cycle_check.
  task automatic trigger(input logic [7:0] v);
    cpu_addr = REG; cpu_wdata = v; cpu_we = 1'b1;
    cycle_check();
    cpu_we = 1'b0; cpu_addr = 16'h8000 + 16'($urandom_range(0, 255));
    trig_t = cyc; model_src = v;
  endtask

  task automatic run_until(input int c);
    while (cyc < c) cycle_check();
  endtask

  task automatic check_oam();
    for (int k = 0; k < NB; k++) check("oam_byte", tb_oam[k], model_oam[k]);
  endtask

  int t1, t2, off;
  logic [7:0] s;

  initial begin
    for (int a = 0; a < 65536; a++) mem[a] = 8'($urandom);
    for (int a = 0; a < 256; a++) mem[16'hC100 + a] = 8'(a);
    for (int k = 0; k < 256; k++) begin tb_oam[k] = 8'h00; model_oam[k] = 8'h00; end
    reset = 1'b1; cpu_addr = '0; cpu_wdata = '0; cpu_we = 1'b0; dma_rdata = '0;
    model_reset();
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;

    // Idle after reset.
    check("rst_dma_addr", dma_addr, 16'h0000);
    check("rst_oam_wdata", oam_wdata, 8'h00);
    clear_stats();
    repeat (100) cycle_check();
    check("idle_busy_cnt", busy_cnt, 0);
    check("idle_rd_seen", first_rd, -1);
    check("idle_we_seen", we_cnt, 0);

    // Full copy from C100.
    clear_stats();
    trigger(8'hC1);
    t1 = trig_t;
    check("rdata_after_write", cpu_rdata, 8'hC1);
    run_until(t1 + BUSY_LEN + 5);
    check("full_busy_cnt", busy_cnt, BUSY_LEN);
    check("full_we_cnt", we_cnt, NB);
    check("full_first_we", first_we - t1, CPB + 1);
    check("full_first_rd", first_rd - t1, CPB);
    for (int k = 0; k < NB; k++) check("full_byte", tb_oam[k], k);
    check("sprite0_y", tb_oam[0], 8'h00);
    check("sprite0_x", tb_oam[1], 8'h01);
    check("sprite0_tile", tb_oam[2], 8'h02);
    check("sprite0_flags", tb_oam[3], 8'h03);

    // Echo region maps E3 to C3.
    clear_stats();
    trigger(8'hE3);
    t1 = trig_t;
    run_until(t1 + BUSY_LEN + 3);
    check("echo_first_addr", first_rd_addr, 16'hC300);
    check("echo_last_addr", dma_addr, 16'hC39F);
    check("echo_rdata", cpu_rdata, 8'hE3);
    check_oam();

    // Restart at the end of slot 49 with a new source.
    clear_stats();
    trigger(8'hC1);
    t1 = trig_t;
    run_until(t1 + (1 + 50) * CPB - 1);
    trigger(8'hD0);
    t2 = trig_t;
    run_until(t2 + BUSY_LEN + 4);
    check("restart_busy_cnt", busy_cnt, (50 + 1 + 161) * CPB);
    check("restart_we_cnt", we_cnt, 50 + NB);
    for (int k = 0; k < NB; k++) check("restart_byte", tb_oam[k], mem[16'hD000 + k]);

    // Random sources with restarts at random points of the copy.
    for (int i = 0; i < 3; i++) begin
      clear_stats();
      s = 8'($urandom);
      trigger(s);
      t1 = trig_t;
      off = $urandom_range(1, BUSY_LEN - 1);
      run_until(t1 + off - 1);
      trigger(8'($urandom));
      t2 = trig_t;
      run_until(t2 + BUSY_LEN + 3);
      check("rand_busy_cnt", busy_cnt, off + BUSY_LEN);
      check_oam();
    end

    // Trigger on the very edge that ends the last slot.
    clear_stats();
    trigger(8'($urandom));
    t1 = trig_t;
    run_until(t1 + BUSY_LEN - 1);
    trigger(8'hC1);
    t2 = trig_t;
    check("end_trig_time", t2 - t1, BUSY_LEN);
    run_until(t2 + BUSY_LEN + 3);
    check("end_trig_busy_cnt", busy_cnt, 2 * BUSY_LEN);
    check_oam();

    // Asynchronous reset during byte 80's read slot.
    for (int k = 0; k < 256; k++) snap_oam[k] = model_oam[k];
    clear_stats();
    trigger(8'hD0);
    t1 = trig_t;
    run_until(t1 + (1 + 80) * CPB);
    #1 reset = 1'b1;
    #1;
    check("arst_busy", busy, 1'b0);
    check("arst_cpu_block", cpu_block, 1'b0);
    check("arst_oam_we", oam_we, 1'b0);
    check("arst_dma_rd", dma_rd, 1'b0);
    check("arst_dma_addr", dma_addr, 16'h0000);
    check("arst_rdata", cpu_rdata, 8'h00);
    model_reset();
    @(posedge clk);
    cyc++;
    #1 reset = 1'b0;
    repeat (20) cycle_check();
    check("arst_we_cnt", we_cnt, 80);
    for (int k = 0; k < 80; k++) check("arst_low_byte", tb_oam[k], mem[16'hD000 + k]);
    for (int k = 80; k < NB; k++) check("arst_kept_byte", tb_oam[k], snap_oam[k]);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
